// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block: duty scale, FSM encoding
// and quotient saturation.
package pwm_pkg;

    localparam int unsigned DUTY_W = 10;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 10'd1023;
    // One extra quotient bit so that high == period (q == 1024) can be seen and clamped.
    localparam int unsigned QUOT_W = DUTY_W + 1;

    typedef enum logic [0:0] {
        StIdle,
        StMeasure
    } state_e;

    function automatic logic [DUTY_W-1:0] sat_duty(input logic [QUOT_W-1:0] q);
        if (q > {1'b0, DUTY_MAX}) begin
            return DUTY_MAX;
        end
        return q[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Control, PWM input and measurement result bundle of pwm_capture.
interface pwm_capture_if #(
    parameter int unsigned CNT_W = 20
);
    import pwm_pkg::*;

    logic              enable;
    logic              pwm_in;
    logic [DUTY_W-1:0] duty;
    logic              duty_valid;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  high_time;
    logic              stuck;
    logic              busy;

    modport master (
        output enable,
        output pwm_in,
        input  duty,
        input  duty_valid,
        input  period,
        input  high_time,
        input  stuck,
        input  busy
    );

    modport slave (
        input  enable,
        input  pwm_in,
        output duty,
        output duty_valid,
        output period,
        output high_time,
        output stuck,
        output busy
    );

endinterface

// File: rtl/pwm_capture_div.sv
// Sequential restoring divider: quotient = floor(dividend * 2^(QUOT_W-1) / divisor),
// one quotient bit per cycle, valid for dividend <= divisor.
module pwm_capture_div
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 20
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              start,
    input  logic [CNT_W-1:0]  dividend,
    input  logic [CNT_W-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic [QUOT_W-1:0] quotient
);

    localparam int unsigned STEP_W = $clog2(QUOT_W);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(QUOT_W - 1);

    logic              busy_q, busy_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W:0]    rem_q, rem_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [QUOT_W-2:0] quot_q, quot_d;

    logic [CNT_W:0] trial;
    logic [CNT_W:0] rem_next;
    logic           ge;
    logic           last;

    // First step compares the dividend itself (quotient MSB); later steps shift first.
    // The remainder is always below the divisor before a shift, so its MSB is free.
    always_comb begin
        trial    = (step_q == '0) ? rem_q : {rem_q[CNT_W-1:0], 1'b0};
        ge       = trial >= {1'b0, div_q};
        rem_next = ge ? (trial - {1'b0, div_q}) : trial;
        last     = step_q == STEP_LAST;
        quotient = {quot_q, ge};
        done     = busy_q & last;
    end

    always_comb begin
        busy_d = busy_q;
        step_d = step_q;
        rem_d  = rem_q;
        div_d  = div_q;
        quot_d = quot_q;
        if (clear) begin
            busy_d = 1'b0;
            step_d = '0;
        end else if (start) begin
            busy_d = 1'b1;
            step_d = '0;
            rem_d  = {1'b0, dividend};
            div_d  = divisor;
            quot_d = '0;
        end else if (busy_q) begin
            rem_d  = rem_next;
            quot_d = quotient[QUOT_W-2:0];
            step_d = step_q + STEP_W'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            step_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            quot_q <= '0;
        end else begin
            busy_q <= busy_d;
            step_q <= step_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            quot_q <= quot_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time between rising edges, reports duty
// on a 0..1023 scale and flags a line with no rising edge as stuck.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_PERIOD  = 16
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    pwm_capture_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s, s_d_q, rise;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]  cap_per_q, cap_per_d;
    logic [CNT_W-1:0]  cap_hi_q, cap_hi_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic              valid_q, valid_d;
    logic              stuck_q, stuck_d;

    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [QUOT_W-1:0] div_quot;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
        s      = sync_q[SYNC_STAGES-1];
        rise   = s & ~s_d_q;
    end

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        cap_per_d = cap_per_q;
        cap_hi_d  = cap_hi_q;
        duty_d    = duty_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        stuck_d   = stuck_q;
        div_start = 1'b0;

        if (!bus.enable) begin
            state_d   = StIdle;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            stuck_d   = 1'b0;
        end else begin
            if (div_done) begin
                duty_d   = sat_duty(div_quot);
                period_d = cap_per_q;
                high_d   = cap_hi_q;
                valid_d  = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d   = StMeasure;
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                        stuck_d   = 1'b0;
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        // The rise cycle belongs to the new period, so it restarts at 1.
                        if (per_cnt_q >= CNT_MIN && !div_busy) begin
                            div_start = 1'b1;
                            cap_per_d = per_cnt_q;
                            cap_hi_d  = hi_cnt_q;
                        end
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                    end else if (per_cnt_q == CNT_MAX) begin
                        // Hold at the limit until any pending divide has been published.
                        if (!div_busy) begin
                            state_d   = StIdle;
                            per_cnt_d = '0;
                            hi_cnt_d  = '0;
                            stuck_d   = 1'b1;
                            duty_d    = s ? DUTY_MAX : '0;
                            period_d  = '0;
                            high_d    = '0;
                            valid_d   = 1'b1;
                        end
                    end else begin
                        per_cnt_d = per_cnt_q + CNT_ONE;
                        if (s) begin
                            hi_cnt_d = hi_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            s_d_q     <= 1'b0;
            state_q   <= StIdle;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            cap_per_q <= '0;
            cap_hi_q  <= '0;
            duty_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            s_d_q     <= s;
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            cap_per_q <= cap_per_d;
            cap_hi_q  <= cap_hi_d;
            duty_q    <= duty_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
        end
    end

    pwm_capture_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .clear    (~bus.enable),
        .start    (div_start),
        .dividend (cap_hi_d),
        .divisor  (cap_per_d),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign bus.duty       = duty_q;
    assign bus.duty_valid = valid_q;
    assign bus.period     = period_q;
    assign bus.high_time  = high_q;
    // A fresh rise clears the stuck flag in the cycle it is seen.
    assign bus.stuck      = stuck_q & ~rise;
    assign bus.busy       = div_busy;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected results, a forked
// monitor pops and compares on every duty_valid.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int unsigned CNT_W       = 12;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned MIN_PERIOD  = 16;
    // Rise consumed on edge SYNC_STAGES+1 after the pwm edge, result published 11 edges later.
    localparam int LAT = SYNC_STAGES + 1 + 11;
    localparam int TMO = SYNC_STAGES + 1 + (1 << CNT_W) - 1;

    typedef struct {
        int duty;
        int per;
        int hi;
        int stuck;
        int cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_capture_if #(.CNT_W(CNT_W)) bus ();

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_PERIOD  (MIN_PERIOD)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int p, input int h, input int st, input int c);
        exp_t e;
        e.duty  = d;
        e.per   = p;
        e.hi    = h;
        e.stuck = st;
        e.cyc   = c;
        sb_q.push_back(e);
    endtask

    // One PWM period starting with a rise; chk means that rise publishes the given result.
    task automatic pulse(input int t, input int th, input bit chk,
                         input int ed, input int ep, input int eh);
        if (chk) push(ed, ep, eh, 0, cyc + LAT);
        for (int i = 0; i < t; i++) begin
            bus.pwm_in = (i < th);
            step();
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.duty_valid) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: duty_valid at cyc %0d duty=%0d, expected none",
                             cyc, bus.duty);
                end else begin
                    e = sb_q.pop_front();
                    if (int'(bus.duty) != e.duty || int'(bus.period) != e.per ||
                        int'(bus.high_time) != e.hi || int'(bus.stuck) != e.stuck ||
                        cyc != e.cyc) begin
                        fails++;
                        $display({"FAIL sb_result: got duty=%0d period=%0d high=%0d stuck=%0d ",
                                  "cyc=%0d, expected duty=%0d period=%0d high=%0d stuck=%0d cyc=%0d"},
                                 bus.duty, bus.period, bus.high_time, bus.stuck, cyc,
                                 e.duty, e.per, e.hi, e.stuck, e.cyc);
                    end
                end
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        fork
            monitor();
        join_none

        bus.enable = 1'b0;
        bus.pwm_in = 1'b0;
        repeat (3) step();
        check("reset_duty", int'(bus.duty), 0);
        check("reset_period", int'(bus.period), 0);
        check("reset_high", int'(bus.high_time), 0);
        check("reset_valid", int'(bus.duty_valid), 0);
        check("reset_stuck", int'(bus.stuck), 0);
        check("reset_busy", int'(bus.busy), 0);
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        repeat (2) step();

        // 1024/870 for four periods: first rise only starts measuring.
        pulse(1024, 870, 0, 0, 0, 0);
        repeat (3) pulse(1024, 870, 1, 870, 1024, 870);
        pulse(100, 50, 1, 870, 1024, 870);
        pulse(100, 1, 1, 512, 100, 50);
        pulse(100, 99, 1, 10, 100, 1);

        // Short periods are dropped; the 8-cycle one also lands while busy.
        pulse(8, 4, 1, 1013, 100, 99);
        pulse(14, 7, 0, 0, 0, 0);
        pulse(200, 100, 0, 0, 0, 0);
        check("glitch_duty", int'(bus.duty), 1013);
        check("glitch_period", int'(bus.period), 100);
        check("glitch_high", int'(bus.high_time), 99);
        pulse(1024, 870, 1, 512, 200, 100);
        pulse(1024, 870, 1, 870, 1024, 870);

        // Abort a divide with enable five cycles into busy.
        bus.pwm_in = 1'b1;
        repeat (7) step();
        check("en_busy_before", int'(bus.busy), 1);
        bus.enable = 1'b0;
        step();
        check("en_busy_cleared", int'(bus.busy), 0);
        repeat (10) step();
        bus.pwm_in = 1'b0;
        repeat (15) step();
        check("en_duty_hold", int'(bus.duty), 870);
        check("en_period_hold", int'(bus.period), 1024);
        check("en_high_hold", int'(bus.high_time), 870);
        check("en_stuck", int'(bus.stuck), 0);
        bus.enable = 1'b1;
        repeat (3) step();
        pulse(1024, 256, 0, 0, 0, 0);
        pulse(1024, 256, 1, 256, 1024, 256);

        // Line held high: timeout reports full duty and flags stuck.
        push(256, 1024, 256, 0, cyc + LAT);
        push(1023, 0, 0, 1, cyc + TMO);
        bus.pwm_in = 1'b1;
        repeat (5000) step();
        check("stuck_high", int'(bus.stuck), 1);
        check("stuck_high_busy", int'(bus.busy), 0);
        bus.pwm_in = 1'b0;
        repeat (4) step();

        // New rise clears stuck in its own cycle; then hold low for a zero-duty timeout.
        push(0, 0, 0, 1, cyc + TMO);
        bus.pwm_in = 1'b1;
        step();
        check("stuck_before_rise", int'(bus.stuck), 1);
        step();
        check("stuck_clear_on_rise", int'(bus.stuck), 0);
        repeat (18) step();
        bus.pwm_in = 1'b0;
        repeat (5000) step();
        check("stuck_low", int'(bus.stuck), 1);
        check("stuck_low_duty", int'(bus.duty), 0);

        pulse(100, 50, 0, 0, 0, 0);
        check("stuck_cleared", int'(bus.stuck), 0);
        pulse(100, 25, 1, 512, 100, 50);

        // Asynchronous reset in the middle of a divide.
        bus.pwm_in = 1'b1;
        repeat (6) step();
        check("rst_busy_before", int'(bus.busy), 1);
        check("rst_duty_before", int'(bus.duty), 512);
        #2;
        rst_n = 1'b0;
        #2;
        check("rst_async_duty", int'(bus.duty), 0);
        check("rst_async_period", int'(bus.period), 0);
        check("rst_async_high", int'(bus.high_time), 0);
        check("rst_async_busy", int'(bus.busy), 0);
        check("rst_async_valid", int'(bus.duty_valid), 0);
        bus.pwm_in = 1'b0;
        step();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        pulse(100, 50, 0, 0, 0, 0);
        pulse(100, 75, 1, 512, 100, 50);
        bus.pwm_in = 1'b0;
        repeat (40) step();

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
